// File: rtl/interval_timer.sv
// Interval timer: counts cycles between start and stop (or a limit timeout), holds the result until acked.
// One-cycle registered latency from sampled inputs to every output.
module interval_timer #(
  parameter int number_of_bits = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic                      stop,
  input  logic [number_of_bits-1:0] limit,
  input  logic                      ack,
  output logic [number_of_bits-1:0] count_val,
  output logic                      busy,
  output logic [number_of_bits-1:0] result,
  output logic                      result_valid,
  output logic                      timeout
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [number_of_bits-1:0] ALL_ONES = '1;
  localparam logic [number_of_bits:0]   INC_ONE  = {{number_of_bits{1'b0}}, 1'b1};

  state_t                    state;
  state_t                    state_next;
  logic [number_of_bits-1:0] eff_limit;
  logic [number_of_bits:0]   count_inc;
  logic                      limit_hit;
  logic                      capture;

  // One extra bit so the all-ones limit compares without wrapping.
  always_comb begin
    eff_limit  = (limit == '0) ? ALL_ONES : limit;
    count_inc  = {1'b0, count_val} + INC_ONE;
    limit_hit  = (count_inc == {1'b0, eff_limit});
    capture    = (state == RUN) && (stop || limit_hit);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (capture) state_next = HOLD;
      HOLD:    if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_val    <= '0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      case (state)
        IDLE: if (start) count_val <= '0;
        RUN: begin
          if (capture) begin
            count_val    <= count_inc[number_of_bits-1:0];
            result       <= count_inc[number_of_bits-1:0];
            result_valid <= 1'b1;
            timeout      <= limit_hit && !stop;
          end else if (!count_inc[number_of_bits]) begin
            // Saturate rather than wrap if limit was lowered below the count mid-run.
            count_val <= count_inc[number_of_bits-1:0];
          end
        end
        HOLD: begin
          if (ack) begin
            result_valid <= 1'b0;
            count_val    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter: number_of_bits, default 8, width of counter, limit and result.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin measurement; sampled on rising clk, level-qualified by state.
REQ-005 stop  input  1  end measurement; sampled on rising clk.
REQ-006 limit  input  number_of_bits  timeout in cycles; 0 = use 2^number_of_bits-1.
REQ-007 ack  input  1  consumer accepts result.
REQ-008 count_val  output  number_of_bits  live elapsed-cycle counter.
REQ-009 busy  output  1  high while in RUN.
REQ-010 result  output  number_of_bits  captured interval.
REQ-011 result_valid  output  1  result and timeout are valid.
REQ-012 timeout  output  1  capture caused by limit, not stop.

Function
REQ-013 Block SHALL implement three registered states: IDLE, RUN, HOLD.
REQ-014 Effective limit L SHALL equal limit when limit != 0, else all-ones; limit sampled every RUN cycle.
REQ-015 IDLE: start=1 -> RUN next cycle with count_val=0; stop and ack ignored; start has priority over simultaneous stop.
REQ-016 RUN: each cycle without capture, count_val SHALL increment by 1; no wrap-around.
REQ-017 RUN capture: stop=1, or count_val+1 == L -> next cycle state HOLD, result=count_val+1, result_valid=1.
REQ-018 timeout SHALL be 1 only for a limit capture with stop=0; stop and limit in the same cycle -> timeout=0.
REQ-019 Result SHALL equal number of rising edges from start sample to capture edge; stop one cycle after start -> result 1.
REQ-020 start in RUN SHALL be ignored (no restart); count_val SHALL freeze at capture value in HOLD.
REQ-021 HOLD: result, timeout, result_valid SHALL hold until ack=1; ack -> IDLE next cycle, result_valid=0, count_val=0.
REQ-022 start in HOLD, including the ack cycle, SHALL be ignored; new measurement requires start in IDLE.
REQ-023 result and timeout SHALL retain last value in IDLE and RUN; only result_valid qualifies them.
REQ-024 busy SHALL be 1 exactly when state is RUN; all outputs registered, no combinational input-to-output path.
REQ-025 Increment arithmetic SHALL be number_of_bits+1 wide internally so count_val+1 == L compares correctly at all-ones.

Reset
REQ-026 reset_n=0 at a rising edge SHALL force IDLE, count_val=0, result=0, result_valid=0, timeout=0, busy=0 regardless of state.
REQ-027 Reset mid-RUN or mid-HOLD SHALL discard the measurement; no result_valid pulse after release.
REQ-028 First start after reset_n returns high SHALL be accepted on the first sampling edge.

Verification (number_of_bits=8)
REQ-029 limit=0, start at edge 0, stop at edge 5 -> edge 5+: result=5, result_valid=1, timeout=0, busy=0; held 10 cycles until ack, then IDLE.
REQ-030 limit=10, start, no stop -> result=10, timeout=1, count_val frozen at 10.
REQ-031 limit=0, start, no stop for 300 cycles -> result=255, timeout=1, count_val never wraps to 0.
REQ-032 start and stop same cycle in IDLE -> RUN entered; stop next cycle -> result=1, timeout=0.
REQ-033 limit=4, stop at the cycle count_val=3 -> result=4, timeout=0.
REQ-034 reset_n=0 at count_val=7 in RUN -> all outputs 0 next edge; ack+start together in HOLD -> IDLE, busy stays 0.
